// File: rtl/butterfly_pipe_mp.sv
// rtl/butterfly_pipe_mp.sv - runtime-switchable mixed-precision radix-2 butterfly with valid/ready pipeline
// Operands pack {re, im} per byte (8-bit Q0.7) or per nibble of [7:0] (4-bit Q0.3 in FP4 mode).

module bf_core #(
   parameter int MUL_BITS = 8,
   parameter int ADD_BITS = 8
) (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] w,
   output logic [15:0] x,
   output logic [15:0] y
);
   localparam int PW = 2 * MUL_BITS + 1;

   logic signed [MUL_BITS-1:0] wr, wi, br, bi;
   logic signed [PW-1:0]       wr_e, wi_e, br_e, bi_e;
   logic signed [PW-1:0]       pr_full, pi_full, pr_sh, pi_sh;
   logic [7:0]                 pr8, pi8, xr8, xi8, yr8, yi8;
   logic [ADD_BITS-1:0]        ar, ai, prn, pin;
   logic                       unused_bits;

   // Each unit truncates operands to its precision by keeping the top bits of every 8-bit component.
   always_comb begin
      wr = w[15 -: MUL_BITS];
      wi = w[7 -: MUL_BITS];
      br = b[15 -: MUL_BITS];
      bi = b[7 -: MUL_BITS];
      wr_e = PW'(wr);
      wi_e = PW'(wi);
      br_e = PW'(br);
      bi_e = PW'(bi);
      pr_full = wr_e * br_e - wi_e * bi_e;
      pi_full = wr_e * bi_e + wi_e * br_e;
      pr_sh = pr_full >>> (MUL_BITS - 1);
      pi_sh = pi_full >>> (MUL_BITS - 1);
      pr8 = '0;
      pi8 = '0;
      pr8[7 -: MUL_BITS] = pr_sh[MUL_BITS-1:0];
      pi8[7 -: MUL_BITS] = pi_sh[MUL_BITS-1:0];
      ar  = a[15 -: ADD_BITS];
      ai  = a[7 -: ADD_BITS];
      prn = pr8[7 -: ADD_BITS];
      pin = pi8[7 -: ADD_BITS];
      xr8 = '0;
      xi8 = '0;
      yr8 = '0;
      yi8 = '0;
      xr8[7 -: ADD_BITS] = ar + prn;
      xi8[7 -: ADD_BITS] = ai + pin;
      yr8[7 -: ADD_BITS] = ar - prn;
      yi8[7 -: ADD_BITS] = ai - pin;
      x = {xr8, xi8};
      y = {yr8, yi8};
   end

   assign unused_bits = ^{a, b, w, pr8, pi8, pr_sh, pi_sh};
endmodule

module butterfly_pipe_mp #(
   parameter int         LATENCY      = 2,
   parameter logic [1:0] DEFAULT_MODE = 2'b01,
   parameter logic [3:0] MODE_MASK    = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode_req,
   output logic [1:0]  mode_active,
   output logic        mode_busy,
   output logic        mode_ack,
   output logic        mode_err,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [15:0] in_w,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_x,
   output logic [15:0] out_y,
   output logic [1:0]  out_mode,
   output logic [2:0]  inflight
);
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

   state_t state_q, state_n;
   logic [1:0]  pend_q;
   logic        pend_load, err_set;
   logic        adv, fire_in, fire_out, req_ok;

   logic [15:0] a4, b4, w4;
   logic [15:0] x4c, y4c, x8, y8, x84, y84, x48, y48;
   logic [15:0] res_x, res_y;
   logic        unused_fp4;

   logic [LATENCY-1:0]       st_v;
   logic [LATENCY-1:0][15:0] st_x, st_y;
   logic [LATENCY-1:0][1:0]  st_m;

   // FP4 nibbles are placed in the top of each 8-bit lane; the upper operand byte never reaches the unit.
   assign a4 = {in_a[7:4], 4'h0, in_a[3:0], 4'h0};
   assign b4 = {in_b[7:4], 4'h0, in_b[3:0], 4'h0};
   assign w4 = {in_w[7:4], 4'h0, in_w[3:0], 4'h0};

   bf_core #(.MUL_BITS(4), .ADD_BITS(4)) u_fp4 (.a(a4), .b(b4), .w(w4), .x(x4c), .y(y4c));
   bf_core #(.MUL_BITS(8), .ADD_BITS(8)) u_fp8 (.a(in_a), .b(in_b), .w(in_w), .x(x8), .y(y8));
   bf_core #(.MUL_BITS(4), .ADD_BITS(8)) u_a8m4 (.a(in_a), .b(in_b), .w(in_w), .x(x84), .y(y84));
   bf_core #(.MUL_BITS(8), .ADD_BITS(4)) u_m8a4 (.a(in_a), .b(in_b), .w(in_w), .x(x48), .y(y48));

   assign unused_fp4 = ^{x4c, y4c};

   always_comb begin
      res_x = x8;
      res_y = y8;
      case (mode_active)
         2'b00: begin
            res_x = {8'h00, x4c[15:12], x4c[7:4]};
            res_y = {8'h00, y4c[15:12], y4c[7:4]};
         end
         2'b10: begin
            res_x = x84;
            res_y = y84;
         end
         2'b11: begin
            res_x = x48;
            res_y = y48;
         end
         default: begin
            res_x = x8;
            res_y = y8;
         end
      endcase
   end

   assign req_ok    = MODE_MASK[mode_req];
   assign adv       = !out_valid | out_ready;
   assign in_ready  = adv & (state_q == ST_RUN) & ((mode_req == mode_active) | !req_ok);
   assign fire_in   = in_valid & in_ready;
   assign fire_out  = out_valid & out_ready;
   assign mode_busy = (state_q != ST_RUN);

   assign out_valid = st_v[LATENCY-1];
   assign out_x     = st_x[LATENCY-1];
   assign out_y     = st_y[LATENCY-1];
   assign out_mode  = st_m[LATENCY-1];

   always_comb begin
      state_n   = state_q;
      pend_load = 1'b0;
      err_set   = 1'b0;
      mode_ack  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!req_ok) begin
               err_set = 1'b1;
            end else if (mode_req != mode_active) begin
               pend_load = 1'b1;
               state_n   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (inflight == 3'd0) state_n = ST_SWITCH;
         end
         ST_SWITCH: begin
            mode_ack = 1'b1;
            state_n  = ST_RUN;
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         mode_active <= DEFAULT_MODE;
         pend_q      <= DEFAULT_MODE;
         mode_err    <= 1'b0;
         inflight    <= 3'd0;
         st_v        <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            st_x[i] <= 16'h0000;
            st_y[i] <= 16'h0000;
            st_m[i] <= DEFAULT_MODE;
         end
      end else begin
         state_q <= state_n;
         if (pend_load) pend_q <= mode_req;
         if (state_q == ST_SWITCH) mode_active <= pend_q;
         if (err_set) mode_err <= 1'b1;
         if (fire_in && !fire_out) inflight <= inflight + 3'd1;
         else if (fire_out && !fire_in) inflight <= inflight - 3'd1;
         // The whole pipe moves as one shift register so results keep their order and mode tag.
         if (adv) begin
            st_v[0] <= fire_in;
            st_x[0] <= res_x;
            st_y[0] <= res_y;
            st_m[0] <= mode_active;
            for (int i = 1; i < LATENCY; i++) begin
               st_v[i] <= st_v[i-1];
               st_x[i] <= st_x[i-1];
               st_y[i] <= st_y[i-1];
               st_m[i] <= st_m[i-1];
            end
         end
      end
   end
endmodule
